elastic_buffer_stage: RTL and testbench

Parameterised synchronous FIFO stage with valid/ready handshakes on both sides. It sits between two buffer blocks in a BLK buffer chain. It absorbs backpressure and decouples the producer cell from the consumer cell. It also reports occupancy, almost-full status and a high-water mark for buffering characterisation.

---
 rtl/elastic_buffer_stage.sv | 78 +++++++
 tb/tb_elastic_buffer_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/elastic_buffer_stage.sv
// Purpose: valid/ready FIFO stage with occupancy, almost-full and high-water-mark reporting.
// Latency: one cycle from push to out_valid (no bypass).
// Backpressure: in_ready drops when full, from registered count only (a full stage refuses a push even on a same-cycle pop).
module elastic_buffer_stage #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   hwm,
  input  logic                     hwm_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    hwm_q, hwm_d;
  logic             push, pop;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign hwm         = hwm_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hwm_d    = hwm_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Clear reloads the post-update occupancy rather than zero.
    if (hwm_clr)               hwm_d = count_d;
    else if (count_d > hwm_q)  hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_elastic_buffer_stage.sv
// Directed plus randomized bench for elastic_buffer_stage, checked against a queue-based model.
module tb_elastic_buffer_stage;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       count;
  logic             almost_full;
  logic [2:0]       hwm;
  logic             hwm_clr;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q[$];
  int               m_hwm;
  bit               last_push;

  elastic_buffer_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .hwm(hwm), .hwm_clr(hwm_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_model();
    chk("count",       32'(count),       32'(q.size()));
    chk("in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
    chk("out_valid",   32'(out_valid),   32'(q.size() != 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("hwm",         32'(hwm),         32'(m_hwm));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // Advance one clock edge and apply the FIFO rules to the model.
  task automatic edge_upd();
    bit do_push, do_pop;
    @(posedge clk);
    do_push = in_valid && (q.size() != DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(in_data);
    if (hwm_clr)              m_hwm = q.size();
    else if (q.size() > m_hwm) m_hwm = q.size();
    last_push = do_push;
    #1;
  endtask

  // Called 1 time unit after a rising edge: check mid-cycle, then clock.
  task automatic cyc();
    #3;
    check_model();
    edge_upd();
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; hwm_clr = 1'b0;
    m_hwm = 0; last_push = 1'b0;
    #12;
    chk("rst_count",     32'(count),       0);
    chk("rst_in_ready",  32'(in_ready),    1);
    chk("rst_out_valid", 32'(out_valid),   0);
    chk("rst_af",        32'(almost_full), 0);
    chk("rst_hwm",       32'(hwm),         0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full, then attempt a fifth push.
    drive(1, 8'h11, 0); cyc();
    drive(1, 8'h22, 0); cyc();
    drive(1, 8'h33, 0); cyc();
    chk("af_after_3rd", 32'(almost_full), 1);
    drive(1, 8'h44, 0); cyc();
    chk("ir_after_4th", 32'(in_ready), 0);
    drive(1, 8'h55, 0); cyc();
    chk("fill_count", 32'(count), 4);
    chk("fill_hwm",   32'(hwm),   4);

    // Drain in order.
    drive(0, 8'h00, 1);
    chk("drain0", 32'(out_data), 32'h11); cyc();
    chk("drain1", 32'(out_data), 32'h22); cyc();
    chk("drain2", 32'(out_data), 32'h33); cyc();
    chk("drain3", 32'(out_data), 32'h44); cyc();
    chk("drain_ov",  32'(out_valid), 0);
    chk("drain_cnt", 32'(count),     0);
    drive(0, 8'h00, 0); cyc();

    // Latency through an empty stage.
    drive(1, 8'hA5, 0);
    #3 chk("lat_pre_ov", 32'(out_valid), 0);
    check_model(); edge_upd();
    drive(0, 8'h00, 0);
    chk("lat_ov",   32'(out_valid), 1);
    chk("lat_data", 32'(out_data),  32'hA5);
    cyc();

    // Asynchronous reset mid-cycle with two words stored.
    drive(1, 8'h66, 0); cyc();
    chk("pre_rst_cnt", 32'(count), 2);
    drive(0, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_count", 32'(count),     0);
    chk("mrst_ov",    32'(out_valid), 0);
    chk("mrst_ir",    32'(in_ready),  1);
    chk("mrst_hwm",   32'(hwm),       0);
    q.delete(); m_hwm = 0;
    #2 rst_n = 1'b1;
    edge_upd();

    // Steady state at count=2 with simultaneous push/pop across pointer wrap.
    drive(1, 8'h00, 0); cyc();
    drive(1, 8'h01, 0); cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h02 + i), 1);
      chk("sim_out", 32'(out_data), 32'(i));
      cyc();
      chk("sim_cnt", 32'(count), 2);
    end

    // Full with simultaneous attempt: pop only, push lands next cycle.
    drive(1, 8'h70, 0); cyc();
    drive(1, 8'h71, 0); cyc();
    chk("full_cnt", 32'(count), 4);
    drive(1, 8'h72, 1); cyc();
    chk("full_pop_only", 32'(count), 3);
    drive(1, 8'h72, 1); cyc();
    chk("push_next", 32'(count), 3);
    drive(0, 8'h00, 0); hwm_clr = 1'b1; cyc();
    hwm_clr = 1'b0;
    chk("hwm_clr3", 32'(hwm), 3);
    // Clear together with a push loads the post-push count.
    drive(0, 8'h00, 1); cyc(); cyc();
    drive(1, 8'h80, 0); hwm_clr = 1'b1; cyc();
    hwm_clr = 1'b0;
    chk("hwm_clr_push", 32'(hwm), 2);

    // Randomized traffic; in_valid/in_data held until accepted.
    drive(0, 8'h00, 0); last_push = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      hwm_clr   = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
